// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } mdu_state_e;

  function automatic logic is_signed_a(input mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_div(input mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/mdu_core.sv
// rtl/mdu_core.sv - shared one-bit-per-cycle datapath: shift-add multiplier / restoring divider plus iteration counter.
module mdu_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] load_lo,
  input  logic [WIDTH-1:0] load_opnd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);

  logic [WIDTH-1:0] opnd;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   trial;

  // hi is the product upper half or the partial remainder; lo is the
  // multiplier being shifted out or the dividend turning into the quotient.
  always_comb begin
    sum   = {1'b0, hi} + {1'b0, (lo[0] ? opnd : {WIDTH{1'b0}})};
    rs    = {hi, lo[WIDTH-1]};
    trial = rs - {1'b0, opnd};
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // The remainder always fits WIDTH bits: a kept trial is below the divisor,
  // and a restored shift value was already below it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      opnd <= '0;
      cnt  <= '0;
    end else if (load) begin
      hi   <= '0;
      lo   <= load_lo;
      opnd <= load_opnd;
      cnt  <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (div_mode) begin
        if (!trial[WIDTH]) begin
          hi <= trial[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi <= rs[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi <= sum[WIDTH:1];
        lo <= {sum[0], lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative RV32M multiply/divide unit: control FSM, operand conditioning and sign fixup.
module mdu
  import mdu_pkg::*;
#(
  parameter int  WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e       state, state_next;
  mdu_op_e          op_in, op_q;
  logic             sa_q, sb_q;
  logic             sa_in, sb_in;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_res;
  logic             accept, step, fix;
  logic [WIDTH-1:0] hi, lo;
  logic             last;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] quo_s, rem_s, fix_res;

  assign op_in = mdu_op_e'(op);

  always_comb begin
    sa_in    = is_signed_a(op_in) & src_a[WIDTH-1];
    sb_in    = is_signed_b(op_in) & src_b[WIDTH-1];
    mag_a    = sa_in ? -src_a : src_a;
    mag_b    = sb_in ? -src_b : src_b;
    div_zero = (src_b == '0);
    div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (src_a == MIN_NEG) && (src_b == '1);
    special  = is_div(op_in) && (div_zero || div_ovf);
    if (div_zero)
      special_res = (op_in inside {OP_REM, OP_REMU}) ? src_a : '1;
    else
      special_res = (op_in inside {OP_REM, OP_REMU}) ? '0 : src_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        accept     = 1'b1;
        state_next = special ? DONE : CALC;
      end
      CALC: begin
        step = 1'b1;
        if (last) state_next = FIXUP;
      end
      FIXUP: begin
        fix        = 1'b1;
        state_next = DONE;
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // flush beats everything, including a same-cycle accept in IDLE
    if (flush) begin
      state_next = IDLE;
      accept     = 1'b0;
      step       = 1'b0;
      fix        = 1'b0;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OP_MUL;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else if (accept) begin
      op_q <= op_in;
      sa_q <= sa_in;
      sb_q <= sb_in;
    end
  end

  mdu_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      (step),
    .div_mode  (is_div(op_q)),
    .load_lo   (is_div(op_in) ? mag_a : mag_b),
    .load_opnd (is_div(op_in) ? mag_b : mag_a),
    .hi        (hi),
    .lo        (lo),
    .last      (last)
  );

  always_comb begin
    prod   = {hi, lo};
    prod_s = (sa_q ^ sb_q) ? -prod : prod;
    quo_s  = (sa_q ^ sb_q) ? -lo : lo;
    rem_s  = sa_q ? -hi : hi;
    case (op_q)
      OP_MUL:                      fix_res = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             fix_res = quo_s;
      default:                     fix_res = rem_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  result <= '0;
    else if (accept && special) result <= special_res;
    else if (fix)                result <= fix_res;
  end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - self-checking bench for mdu: vector table, random ops against a model, and abort/backpressure sequences.
module tb_mdu;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  mdu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int           lat;
  } vec_t;

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  vec_t         vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sb, zb, sp;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    zb = {32'd0, b};
    case (o)
      3'd0: begin sp = sa * sb; p = sp; return p[31:0]; end
      3'd1: begin sp = sa * sb; p = sp; return p[63:32]; end
      3'd2: begin sp = sa * zb; p = sp; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        sp = sa % sb; return sp[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drives one op in IDLE, checks latency, busy in_ready, scoreboard result,
  // optionally holds out_ready low for `hold` cycles, then handshakes.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input int exp_lat, input int hold, input string nm);
    int cyc;
    bit busy_hi;
    bit unstable;
    logic [W-1:0] held;
    exp_q.push_back(exp_res);
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    busy_hi = 0;
    while (!out_valid && cyc < 100) begin
      if (in_ready) busy_hi = 1;
      @(posedge clk); #1;
      cyc++;
    end
    if (in_ready) busy_hi = 1;
    check({nm, "_lat"}, cyc, exp_lat);
    check({nm, "_busy"}, busy_hi, 0);
    if (out_valid && exp_q.size() > 0) check({nm, "_res"}, result, exp_q.pop_front());
    else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      check({nm, "_outvalid"}, out_valid, 1);
    end
    held = result;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) unstable = 1;
    end
    if (hold > 0) check({nm, "_hold"}, unstable, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "_ready_after"}, in_ready, 1);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
    vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[12] = '{3'd0, 32'd0,          32'h0001_2345, 32'd0,         34};
    vecs[13] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34};
    vecs[14] = '{3'd7, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34};
    vecs[15] = '{3'd4, 32'hFFFF_FFFF,  32'd0,         32'hFFFF_FFFF, 1};
    vecs[16] = '{3'd1, 32'hFFFF_FFFF,  32'd7,         32'hFFFF_FFFF, 34};
    vecs[17] = '{3'd0, 32'h1234_5678,  32'h10,        32'h2345_6780, 34};

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 0, $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      logic [2:0]   o;
      logic [W-1:0] a, b;
      int           lat;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i == 3) ? '0 : ((i == 5) ? W'($urandom_range(1, 9)) : $urandom);
      lat = (o[2] && (b == 0 || (a == 32'h8000_0000 && b == '1 && !o[0]))) ? 1 : 34;
      run_op(o, a, b, model(o, a, b), lat, 0, $sformatf("rnd%0d", i));
    end

    run_op(3'd5, 32'd1000, 32'd3, 32'd333, 34, 5, "bp");
    run_op(3'd0, 32'd6, 32'd9, 32'd54, 34, 0, "b2b");

    begin : flush_calc
      bit seen;
      op = 3'd0; src_a = 32'd11; src_b = 32'd13; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_in_ready", in_ready, 1);
      check("flush_out_valid", out_valid, 0);
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1; end
      check("flush_no_result", seen, 0);
    end

    op = 3'd5; src_a = 32'd5; src_b = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", in_ready, 1);
    check("flush_idle_valid", out_valid, 0);

    run_op(3'd0, 32'd7, 32'd3, 32'd21, 34, 0, "pre_rst");
    op = 3'd4; src_a = 32'd100; src_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_result", result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
